// File: rtl/asip_read_pkg.sv
// asip_read_pkg: shared constants for the ASIP memory read path
package asip_read_pkg;
  localparam logic OP_SCALAR    = 1'b0;
  localparam logic OP_VECTOR    = 1'b1;
  localparam int   SCALAR_COUNT = 1;
  localparam int   VECTOR_ITEMS = 20;
endpackage

// File: rtl/rd_counter.sv
// rd_counter: A-bit read offset up-counter with enable and async clear
module rd_counter #(
  parameter int A = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [A-1:0] counter
);
  logic [A-1:0] r_count;
  // advance one element per cycle while enabled, wrapping naturally at 2^A
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else if (en) r_count <= r_count + 1'b1;
  assign counter = r_count;
endmodule

// File: rtl/finished_signal.sv
// finished_signal: read sequencing, sticky done flag once target offset reached
module finished_signal
  import asip_read_pkg::*;
#(
  parameter int A = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_type,
  input  logic [A-1:0] vector_max,
  output logic [A-1:0] counter,
  output logic         finished
);
  logic [A-1:0] w_target;
  logic [A-1:0] w_counter;
  logic         r_finished;
  assign w_target = (op_type == OP_VECTOR) ? vector_max : A'(SCALAR_COUNT);
  rd_counter #(.A(A)) u_rd_counter (
    .clk    (clk),
    .rst    (rst),
    .en     (~r_finished),
    .counter(w_counter)
  );
  // latch completion once the pre-edge offset meets the live target
  always_ff @(posedge clk or posedge rst)
    if (rst) r_finished <= 1'b0;
    else r_finished <= r_finished | (w_counter >= w_target);
  assign counter  = w_counter;
  assign finished = r_finished;
endmodule

// File: tb/tb_finished_signal.sv
// tb_finished_signal: scoreboard bench for finished_signal
module tb_finished_signal;
  localparam int A = 6;
  typedef struct packed {
    logic [A-1:0] c;
    logic         f;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_type = 1'b0;
  logic [A-1:0] vector_max = 6'd20;
  logic [A-1:0] counter;
  logic         finished;
  int           n_chk = 0;
  int           n_err = 0;
  exp_t         q[$];
  logic [A-1:0] m_cnt = '0;
  logic         m_fin = 1'b0;
  finished_signal #(.A(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_type   (op_type),
    .vector_max(vector_max),
    .counter   (counter),
    .finished  (finished)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  // reference model: pushes the expected post-edge state at every edge
  always @(posedge clk or posedge rst) begin
    logic [A-1:0] tgt;
    logic [A-1:0] nc;
    logic         nf;
    if (rst) begin
      m_cnt = '0;
      m_fin = 1'b0;
      q.delete();
    end else begin
      tgt = op_type ? vector_max : A'(1);
      nf  = m_fin || (m_cnt >= tgt);
      nc  = m_fin ? m_cnt : m_cnt + 1'b1;
      m_cnt = nc;
      m_fin = nf;
      q.push_back('{c: nc, f: nf});
    end
  end
  // compare DUT against scoreboard away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sb_counter", int'(counter), int'(e.c));
      chk("sb_finished", int'(finished), int'(e.f));
    end
  end
  task automatic restart(input logic op, input logic [A-1:0] vm);
    @(negedge clk);
    #2 rst = 1'b1;
    op_type = op;
    vector_max = vm;
    #1 chk("rst_counter", int'(counter), 0);
    chk("rst_finished", int'(finished), 0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask
  task automatic run_done(input string tag, input int exp_edges, input int exp_cnt);
    int e = 0;
    while (!finished && e < 200) begin
      @(posedge clk);
      #1 e++;
    end
    chk({tag, "_edges"}, e, exp_edges);
    chk({tag, "_counter"}, int'(counter), exp_cnt);
    chk({tag, "_finished"}, int'(finished), 1);
  endtask
  initial begin
    int e;
    repeat (3) @(posedge clk);
    #1 chk("reset_counter", int'(counter), 0);
    chk("reset_finished", int'(finished), 0);
    @(negedge clk);
    #2 op_type = 1'b1;
    vector_max = 6'd20;
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("pre_async_counter", int'(counter), 7);
    #1 rst = 1'b1;
    #1 chk("async_counter", int'(counter), 0);
    chk("async_finished", int'(finished), 0);
    restart(1'b0, 6'd20);
    chk("scalar_c0", int'(counter), 0);
    @(posedge clk);
    #1 chk("scalar_c1", int'(counter), 1);
    chk("scalar_f1", int'(finished), 0);
    @(posedge clk);
    #1 chk("scalar_c2", int'(counter), 2);
    chk("scalar_f2", int'(finished), 1);
    repeat (10) @(posedge clk);
    #1 chk("scalar_hold_c", int'(counter), 2);
    chk("scalar_hold_f", int'(finished), 1);
    restart(1'b1, 6'd20);
    run_done("vec20", 21, 21);
    repeat (5) @(posedge clk);
    #1 chk("vec20_hold_c", int'(counter), 21);
    restart(1'b1, 6'd0);
    run_done("vec0", 1, 1);
    restart(1'b1, 6'd63);
    run_done("vec63", 64, 0);
    repeat (3) @(posedge clk);
    #1 chk("vec63_hold_c", int'(counter), 0);
    restart(1'b1, 6'd20);
    e = 0;
    while (counter != 6'd5 && e < 50) begin
      @(posedge clk);
      #1 e++;
    end
    chk("mid_reach5", e, 5);
    op_type = 1'b0;
    @(posedge clk);
    #1 chk("mid_finished", int'(finished), 1);
    chk("mid_counter", int'(counter), 6);
    restart(1'b1, 6'd3);
    run_done("abort_vec3", 4, 4);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/finished_signal.md
# finished_signal

Read-sequencing control for the vector ASIP's memory read path. It holds the element offset counter (`rd_counter` sub-module) and raises a sticky `finished` flag once the last required element has been addressed. Scalar reads need one element; vector reads need `vector_max` elements. It sits beside the read-data capture register, which forms `read_address = counter + base_address` and uses `counter` to steer captured words into vector lanes.

## Interface
Parameters:
- `A`, default 6: width of the offset counter and of `vector_max`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `op_type`  in  1: operation type; 0 = scalar read, 1 = vector read.
- `vector_max`  in  A: number of elements in a vector read (20 in the current ASIP build).
- `counter`  out  A: current read offset, registered.
- `finished`  out  1: read sequence complete, registered and sticky.

## Operation
- Target count: `target = (op_type == 1) ? vector_max : 1`. It is combinational and re-evaluated every cycle.
- Counter (`rd_counter`):
  - Increments by 1 on each rising edge while `finished == 0`.
  - Holds its value while `finished == 1`.
  - Arithmetic is unsigned A-bit. It wraps from 2^A−1 to 0; this is only reachable when `vector_max = 2^A−1`.
- Finished: on each rising edge, `finished <= finished | (counter >= target)`.
  - The comparison is unsigned A-bit against the pre-edge `counter`.
  - Once set, `finished` stays 1 until `rst`.
- `op_type` or `vector_max` may change mid-sequence. Because the test is `>=`, lowering the target below the current counter ends the sequence on the next edge. Raising the target before `finished` is set extends the sequence.
- `vector_max = 0` in vector mode: `finished` sets on the first edge after reset and `counter` ends at 1.
- There are no other states. The block is effectively two states:
  - COUNTING (`finished = 0`).
  - DONE (`finished = 1`).
  - COUNTING → DONE when `counter >= target` at a rising edge.
  - DONE → COUNTING only via `rst`.

## Timing
- Reset values: `counter = 0`, `finished = 0`.
  - Both clear immediately on `rst` assertion, independent of `clk`.
  - Both hold while `rst` is high.
- `counter` sequence after reset release is 0, 1, …, target, target+1. At the edge where `counter` goes target → target+1, `finished` rises in the same edge and `counter` then freezes at target+1.
- Latency from reset release to `finished = 1`: target+1 rising edges.
  - Scalar: 2 edges.
  - Vector with `vector_max = 20`: 21 edges.
- `rst` asserted mid-sequence or after DONE aborts immediately. The next sequence restarts from `counter = 0`.
- Outputs are glitch-free register outputs. There is no combinational path from inputs to outputs.

## Structure
- Shared package `asip_read_pkg`:
  - `OP_SCALAR = 1'b0`, `OP_VECTOR = 1'b1`.
  - `SCALAR_COUNT = 1`.
  - `VECTOR_ITEMS = 20` (default `vector_max` tie-off used by the read module).
- Sub-module `rd_counter #(A)`:
  - Ports: `clk`, `rst`, `en`, `counter`.
  - A-bit up-counter with asynchronous active-high clear.
  - `en = ~finished`.
- The target mux, comparator and sticky `finished` flop live in `finished_signal`.

## Test plan
- Reset: assert `rst` mid-clock with `counter` = 7 → `counter = 0` and `finished = 0` immediately, before the next edge.
- Scalar: `op_type = 0`, release reset.
  - `counter` reads 0 then 1.
  - `finished` rises at edge 2 with `counter = 2`.
  - Both are held for 10 further cycles.
- Vector: `op_type = 1`, `vector_max = 20`.
  - `counter` steps 0..20.
  - `finished` rises at edge 21 with `counter = 21`.
  - Both are stable afterwards.
- Edge values:
  - `vector_max = 0`, vector mode → `finished` at edge 1, `counter = 1`.
  - `vector_max = 63`, A = 6 → `counter` wraps 63 → 0 as `finished` rises at edge 64, and the counter then holds at 0.
- Mid-sequence change: vector, `vector_max = 20`; switch `op_type` to 0 when `counter = 5` → `finished` rises on the next edge, `counter = 6`.
- Abort/restart: assert `rst` during DONE, release, run vector with `vector_max = 3` → `finished` at edge 4, `counter = 4`.
